// File: rtl/four_dmx.sv
// Registered 1-to-4 time-division demultiplexer. Lanes are selected by an external
// select or by a sync-aligned slot counter that also assembles complete frames.
module four_dmx #(
  parameter int DW = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            ext_mode,
  input  logic [1:0]      sel,
  input  logic            sync,
  input  logic [DW-1:0]   din,
  input  logic            clr_err,
  output logic [4*DW-1:0] y,
  output logic [4*DW-1:0] frame,
  output logic            frame_valid,
  output logic [1:0]      slot,
  output logic            sync_err
);

  // state | meaning
  // HUNT  | waiting for sync to mark slot 0 of a frame
  // LOCK  | aligned; slot_q is the next lane to fill
  typedef enum logic {HUNT, LOCK} state_t;

  state_t          state_q, state_d;
  logic [4*DW-1:0] y_q, y_d;
  logic [4*DW-1:0] frame_q, frame_d;
  logic            frame_valid_q, frame_valid_d;
  logic [1:0]      slot_q, slot_d;
  logic            sync_err_q, sync_err_d;

  logic            lane_we;
  logic [1:0]      lane_idx;
  logic            err_set;

  always_comb begin
    state_d       = state_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    slot_d        = slot_q;
    lane_we       = 1'b0;
    lane_idx      = 2'd0;
    err_set       = 1'b0;

    if (ext_mode) begin
      state_d  = HUNT;
      slot_d   = 2'd0;
      lane_we  = en;
      lane_idx = sel;
    end else if (en) begin
      if (state_q == HUNT) begin
        if (sync) begin
          lane_we  = 1'b1;
          lane_idx = 2'd0;
          slot_d   = 2'd1;
          state_d  = LOCK;
        end
      end else if (sync && (slot_q != 2'd0)) begin
        // Realign on an early sync; the partial frame is dropped.
        lane_we  = 1'b1;
        lane_idx = 2'd0;
        slot_d   = 2'd1;
        err_set  = 1'b1;
      end else begin
        lane_we  = 1'b1;
        lane_idx = slot_q;
        slot_d   = slot_q + 2'd1;
        if (slot_q == 2'd3) begin
          frame_d       = {din, y_q[3*DW-1:0]};
          frame_valid_d = 1'b1;
        end
      end
    end

    y_d = y_q;
    for (int k = 0; k < 4; k++) begin
      if (lane_we && (lane_idx == k[1:0])) begin
        y_d[DW*k +: DW] = din;
      end
    end

    // A new error on the same edge as clr_err wins.
    sync_err_d = err_set | (sync_err_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= HUNT;
      y_q           <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      slot_q        <= 2'd0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      y_q           <= y_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      slot_q        <= slot_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign y           = y_q;
  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign slot        = slot_q;
  assign sync_err    = sync_err_q;

endmodule

// File: doc/four_dmx.md
# four_dmx

Registered 1-to-4 time-division demultiplexer: the receive-side counterpart of the four-input multiplexer. A lane-serial stream on `din` is routed into four registered lane outputs. The lane is chosen either by an external `sel` or by an internal slot counter aligned to a frame `sync`. In counter mode, each completed 4-slot frame is presented as a parallel word with a one-cycle valid pulse.

## Interface
- `DW`, default 1, width of one lane (one sample).
- `clk`  input  1  rising-edge clock, single clock domain.
- `rst`  input  1  asynchronous, active-high reset.
- `en`  input  1  sample `din` on this edge.
- `ext_mode`  input  1  1: lane = `sel`; 0: lane = internal slot counter.
- `sel`  input  2  destination lane in external mode.
- `sync`  input  1  marks slot 0 of a frame; meaningful only when `en`=1 and `ext_mode`=0.
- `din`  input  DW  serial lane data.
- `clr_err`  input  1  clears `sync_err`.
- `y`  output  4*DW  lane registers; lane k is `y[DW*k +: DW]`.
- `frame`  output  4*DW  last completed frame; lane k is `frame[DW*k +: DW]`.
- `frame_valid`  output  1  one-cycle pulse when `frame` updates.
- `slot`  output  2  next slot to be written (counter mode).
- `sync_err`  output  1  sticky misaligned-sync flag.

## Operation
- Reset values:
  - `y`=0, `frame`=0, `frame_valid`=0, `slot`=0, `sync_err`=0.
  - State = HUNT.
- External mode (`ext_mode`=1):
  - `en`=1: `y[sel]` <= `din`; other lanes hold.
  - State forced to HUNT and `slot` to 0 every cycle.
  - `frame` and `frame_valid` are never updated (`frame_valid`=0).
- Counter mode (`ext_mode`=0) is a two-state FSM.
  - HUNT:
    - `en`=1 with `sync`=0: ignored, no lane write.
    - `en`=1 with `sync`=1: lane 0 <= `din`, `slot` <= 1, go to LOCK.
  - LOCK, each `en`=1 edge:
    - lane[`slot`] <= `din`, and `slot` <= `slot`+1 (mod 4, wraps 3->0).
    - When `slot`=3: `frame` <= {`din`, lane2, lane1, lane0}, where lanes 0..2 are the values written this frame. `frame_valid` pulses.
    - `sync`=1 with `slot`=0: normal frame start.
    - `sync`=1 with `slot`!=0: realign. Lane 0 <= `din`, `slot` <= 1, partial frame discarded (no `frame_valid`), `sync_err` <= 1.
  - LOCK, `en`=0: all state holds. Gaps of any length are allowed mid-frame.
- Switching `ext_mode` 0->1 mid-frame abandons the partial frame. Lanes keep already-written values.
- `sync_err` is sticky until a `clr_err` edge. If a set and `clr_err` occur on the same edge, set wins.

## Timing
- All outputs are registered.
- `y`, `slot`, `frame`, and `sync_err` change on the rising edge that samples `en`=1. They are visible in the following cycle (1-cycle latency).
- `frame_valid` is high for exactly the one cycle after the slot-3 sampling edge, aligned with the new `frame` value. It never stays high for two consecutive cycles unless two frames complete on consecutive `en` edges. Back-to-back frames with `en` held high give one pulse every 4 cycles.
- `rst` asserted at any time, including mid-frame, immediately forces the reset values without waiting for `clk`. The first frame after deassertion requires `sync` (HUNT).
- `sel`, `sync`, `din`, `ext_mode`, and `clr_err` are sampled only at rising edges. No combinational path exists from inputs to outputs.

## Test plan
- External mode, DW=1: with `en`=1, apply `sel`=00,01,10,11 with `din`=0,1,0,1 -> after 4 edges `y`=4'b1010. `frame_valid` stays 0 and `slot` stays 0.
- Counter mode: `sync`=1 with `din`=0 on slot 0, then `din`=1,0,1 -> `frame`=4'b1010. `frame_valid` is high exactly one cycle after the 4th edge, and `slot` returns to 0.
- HUNT filtering: after reset, 3 `en` edges with `sync`=0 and `din`=1 -> `y`=0 and `slot`=0. The next edge with `sync`=1 and `din`=1 gives `y`=4'b0001 and `slot`=1.
- Gaps and back-to-back frames:
  - Insert `en`=0 for 3 cycles between slots 1 and 2 -> `slot` holds at 2, and the frame still completes as 4'b1100 from `din`=0,0,1,1.
  - A second frame, 4'b0101, follows immediately; its pulse comes 4 cycles after the first.
- Misaligned sync:
  - In LOCK at `slot`=2, apply `sync`=1 with `din`=0 -> `sync_err`=1, `slot`=1, no `frame_valid`.
  - Completing 1,1,0 then yields `frame`=4'b0110.
  - `clr_err` then clears `sync_err` to 0. `clr_err` on the same edge as a new misaligned sync leaves `sync_err`=1.
- Reset mid-frame: assert `rst` asynchronously between edges at `slot`=2 -> all outputs are 0 immediately. After release, an `en` edge without `sync` is ignored.
